pcl_valve_seq: RTL and testbench
================================

# pcl_valve_seq

Synchronous sequencer driving the two pneumatic control lines of a two-reagent valve-and-mix stage. Each reagent valve sits on one inlet, and both inlets feed a diffusion mixer. On a start request the sequencer:
- opens reagent 1 for a programmed number of cycles,
- opens reagent 2 for a programmed number of cycles, with a dead time after each dose so both valves are never open together,
- holds both valves closed for a mix interval,
- then reports completion.

It is the control-side counterpart of the fluidic valve/mixer netlist: that netlist consumes the pneumatic inputs, and this block produces them.

## Interface
- CNT_W, 16, width of all duration inputs and internal counters
- DEAD_CYCLES, 4, cycles with both valves closed after each dose (≥1)
- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- start  in  1  request a dose/mix run; sampled only in IDLE
- abort  in  1  terminate a run immediately; highest priority after rst
- dose1_cycles  in  CNT_W  reagent-1 open time, latched at start
- dose2_cycles  in  CNT_W  reagent-2 open time, latched at start
- mix_cycles  in  CNT_W  post-dose mix hold, latched at start
- pn_ctl1  out  1  valve-1 pressurize; 1 = closed
- pn_ctl2  out  1  valve-2 pressurize; 1 = closed
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse when abort ends a run

## Operation
- States and their outputs:
  - IDLE: pn_ctl1=1, pn_ctl2=1.
  - DOSE1: pn_ctl1=0, pn_ctl2=1.
  - DEAD1: both 1.
  - DOSE2: pn_ctl1=1, pn_ctl2=0.
  - DEAD2: both 1.
  - MIX: both 1.
  - DONE: both 1; lasts one cycle; done=1.
- Valve-control outputs are fail-safe. In every state except DOSE1/DOSE2, both pn_ctl outputs are 1.
- Start: start=1 in IDLE latches all three durations and enters DOSE1. start outside IDLE is ignored and not queued.
- Zero-length phases are skipped and take no cycles:
  - dose1_cycles=0: skip DOSE1 and DEAD1.
  - dose2_cycles=0: skip DOSE2 and DEAD2.
  - mix_cycles=0: skip MIX.
  - All zero: start goes straight to DONE.
- Durations: a single down-counter is loaded with (duration−1) on entry to each timed phase. The phase exits on the cycle the counter reads 0, so each phase lasts exactly its programmed number of cycles. DEAD phases load DEAD_CYCLES−1.
- Maximum phase length is 2^CNT_W−1 cycles. The counter never wraps.
- Abort: abort=1 in any non-IDLE state forces IDLE on the next edge.
  - Both valves are closed from that edge onward.
  - aborted=1 for that one cycle; done is not pulsed.
  - abort in IDLE has no effect and no aborted pulse.
  - start and abort together in IDLE: abort has no effect, so the run starts.
- Reset: forces IDLE. Counter=0, latched durations=0, pn_ctl1=pn_ctl2=1, busy=0, done=0, aborted=0. Reset mid-run behaves as abort but without the aborted pulse.
- The durations inputs may change freely while busy without affecting the run in progress.

## Timing
- All outputs are registered.
- Start at edge t (start=1 sampled in IDLE) → at t+1: state=DOSE1, pn_ctl1=0, busy=1.
- Full run, cycles counted from t+1: D1 + DEAD + D2 + DEAD + M, then DONE for one cycle.
- done and aborted are each high for exactly one cycle. busy=1 during DONE and falls the following cycle.
- A new start is accepted in the first IDLE cycle after DONE, so back-to-back runs are separated by one IDLE cycle minimum.
- No cycle exists in which pn_ctl1=0 and pn_ctl2=0.

## Structure
- Shared package `pcl_valve_pkg`:
  - state enum (IDLE, DOSE1, DEAD1, DOSE2, DEAD2, MIX, DONE);
  - constant VALVE_CLOSED=1'b1.
- One sub-module, `phase_timer`: loadable CNT_W down-counter with a zero flag; parameter CNT_W; ports clk, rst, load, load_val, zero.
- The FSM, including next-phase skip logic, lives in the top module.

## Test plan
- Reset with start held high → all outputs at reset values; state IDLE after rst falls, then start is taken.
- dose1=3, dose2=2, mix=5, DEAD_CYCLES=4 → pn_ctl1 low cycles 1–3, both high 4–7, pn_ctl2 low 8–9, both high 10–18, done pulse at cycle 19, busy low at 20.
- dose1=0, dose2=4, mix=0 → first cycle after start has pn_ctl2=0; done 4+4 cycles later; pn_ctl1 never low.
- abort asserted during cycle 2 of DOSE2 → next cycle both pn_ctl=1, aborted=1 for one cycle, busy=0, no done.
- Start pulses during busy, plus dose inputs changed mid-run → ignored; timing matches the latched values.
- Randomized durations, 1000 runs → assertion: never pn_ctl1=0 && pn_ctl2=0; done count equals completed runs.

Source files
------------

// File: rtl/pcl_valve_seq_pkg.sv
// -----------------------------------------------------------------------------
// pcl_valve_pkg
// Shared definitions for the two-reagent valve/mix sequencer:
//   state_e       - sequencer phases
//   VALVE_CLOSED  - level that pressurizes (closes) a pneumatic valve line
//   next_timed()  - picks the first non-empty phase from a set of candidates
// -----------------------------------------------------------------------------
package pcl_valve_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DOSE1 = 3'd1,
        ST_DEAD1 = 3'd2,
        ST_DOSE2 = 3'd3,
        ST_DEAD2 = 3'd4,
        ST_MIX   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam logic VALVE_CLOSED = 1'b1;

    // Zero-length phases take no cycles, so the sequencer jumps straight to
    // the first remaining phase with a non-zero duration. Callers clear the
    // flags of phases already behind them.
    function automatic state_e next_timed(input logic dose1_nz,
                                          input logic dose2_nz,
                                          input logic mix_nz);
        if (dose1_nz)
            return ST_DOSE1;
        else if (dose2_nz)
            return ST_DOSE2;
        else if (mix_nz)
            return ST_MIX;
        else
            return ST_DONE;
    endfunction

endpackage

// File: rtl/pcl_valve_seq_if.sv
// -----------------------------------------------------------------------------
// pcl_valve_seq_if
// Control/status bundle of the valve sequencer.
//   master : drives start/abort/durations, observes valve lines and status
//   slave  : the sequencer itself
// Signals:
//   start, abort                          - run control
//   dose1_cycles, dose2_cycles, mix_cycles - phase durations (CNT_W bits)
//   pn_ctl1, pn_ctl2                       - pneumatic lines, 1 = valve closed
//   busy, done, aborted                    - run status
// -----------------------------------------------------------------------------
interface pcl_valve_seq_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] dose1_cycles;
    logic [CNT_W-1:0] dose2_cycles;
    logic [CNT_W-1:0] mix_cycles;
    logic             pn_ctl1;
    logic             pn_ctl2;
    logic             busy;
    logic             done;
    logic             aborted;

    modport master (
        output start, abort, dose1_cycles, dose2_cycles, mix_cycles,
        input  pn_ctl1, pn_ctl2, busy, done, aborted
    );

    modport slave (
        input  start, abort, dose1_cycles, dose2_cycles, mix_cycles,
        output pn_ctl1, pn_ctl2, busy, done, aborted
    );
endinterface

// File: rtl/pcl_valve_seq_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that times one sequencer phase. Loaded with
// (duration-1) on phase entry; holds at zero so it can never wrap.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (counter cleared)
//   load      - load load_val this cycle (has priority over counting)
//   load_val  - value to load
//   zero      - counter currently reads 0 (last cycle of the phase)
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/pcl_valve_seq.sv
// -----------------------------------------------------------------------------
// pcl_valve_seq
// Sequencer for a two-reagent valve-and-mix stage: dose reagent 1, dead time,
// dose reagent 2, dead time, mix hold, then a one-cycle completion pulse.
// The two valves are never open together; every non-dosing state keeps both
// pneumatic lines pressurized.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   bus       - pcl_valve_seq_if.slave (start/abort/durations in,
//               pn_ctl1/pn_ctl2/busy/done/aborted out, all registered)
// -----------------------------------------------------------------------------
module pcl_valve_seq
    import pcl_valve_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DEAD_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    pcl_valve_seq_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dose1_q, dose2_q, mix_q;
    logic [CNT_W-1:0] dose1_sel, dose2_sel, mix_sel;
    logic             pn_ctl1_q, pn_ctl2_q, busy_q, done_q, aborted_q;
    logic             abort_hit;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // On the start edge the latches are not yet written, so the first phase
    // decision and its counter load use the live inputs.
    assign dose1_sel = (state_q == ST_IDLE) ? bus.dose1_cycles : dose1_q;
    assign dose2_sel = (state_q == ST_IDLE) ? bus.dose2_cycles : dose2_q;
    assign mix_sel   = (state_q == ST_IDLE) ? bus.mix_cycles   : mix_q;

    always_comb begin
        state_d   = state_q;
        abort_hit = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        unique case (state_q)
            ST_IDLE:  if (bus.start)
                          state_d = next_timed(dose1_sel != '0, dose2_sel != '0,
                                               mix_sel != '0);
            ST_DOSE1: if (tmr_zero) state_d = ST_DEAD1;
            ST_DEAD1: if (tmr_zero)
                          state_d = next_timed(1'b0, dose2_sel != '0,
                                               mix_sel != '0);
            ST_DOSE2: if (tmr_zero) state_d = ST_DEAD2;
            ST_DEAD2: if (tmr_zero)
                          state_d = next_timed(1'b0, 1'b0, mix_sel != '0);
            ST_MIX:   if (tmr_zero) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && bus.abort) begin
            state_d   = ST_IDLE;
            abort_hit = 1'b1;
        end

        // No phase ever follows itself, so a state change marks phase entry.
        if (state_d != state_q) begin
            unique case (state_d)
                ST_DOSE1: begin tmr_load = 1'b1; tmr_val = dose1_sel - CNT_W'(1); end
                ST_DOSE2: begin tmr_load = 1'b1; tmr_val = dose2_sel - CNT_W'(1); end
                ST_MIX:   begin tmr_load = 1'b1; tmr_val = mix_sel - CNT_W'(1);   end
                ST_DEAD1,
                ST_DEAD2: begin tmr_load = 1'b1; tmr_val = DEAD_LOAD;             end
                default:  begin tmr_load = 1'b0; tmr_val = '0;                    end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dose1_q   <= '0;
            dose2_q   <= '0;
            mix_q     <= '0;
            pn_ctl1_q <= VALVE_CLOSED;
            pn_ctl2_q <= VALVE_CLOSED;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start) begin
                dose1_q <= bus.dose1_cycles;
                dose2_q <= bus.dose2_cycles;
                mix_q   <= bus.mix_cycles;
            end
            // Outputs follow the state being entered so they are registered
            // yet aligned with the state register.
            pn_ctl1_q <= (state_d == ST_DOSE1) ? ~VALVE_CLOSED : VALVE_CLOSED;
            pn_ctl2_q <= (state_d == ST_DOSE2) ? ~VALVE_CLOSED : VALVE_CLOSED;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            aborted_q <= abort_hit;
        end
    end

    assign bus.pn_ctl1 = pn_ctl1_q;
    assign bus.pn_ctl2 = pn_ctl2_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
endmodule

// File: tb/tb_pcl_valve_seq.sv
// -----------------------------------------------------------------------------
// tb_pcl_valve_seq
// Self-checking bench for pcl_valve_seq. A run is modelled as the list of
// output vectors {pn_ctl1, pn_ctl2, busy, done, aborted} it must produce,
// built from the durations captured at start; abort/reset drop the list.
// Directed runs additionally check hand-computed cycle-by-cycle values.
// -----------------------------------------------------------------------------
module tb_pcl_valve_seq;
    localparam int CNT_W = 16;
    localparam int DEAD  = 4;

    localparam logic [4:0] V_IDLE  = 5'b11000;
    localparam logic [4:0] V_ABORT = 5'b11001;
    localparam logic [4:0] V_D1    = 5'b01100;
    localparam logic [4:0] V_D2    = 5'b10100;
    localparam logic [4:0] V_SHUT  = 5'b11100;
    localparam logic [4:0] V_DONE  = 5'b11110;

    logic clk;
    logic rst;

    pcl_valve_seq_if #(.CNT_W(CNT_W)) bus ();

    pcl_valve_seq #(.CNT_W(CNT_W), .DEAD_CYCLES(DEAD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail = 0;
    int n_done_model = 0;
    int n_done_dut = 0;
    int cyc = 0;

    logic [4:0] exp_q[$];
    logic [4:0] cur = V_IDLE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] dut_vec();
        return {bus.pn_ctl1, bus.pn_ctl2, bus.busy, bus.done, bus.aborted};
    endfunction

    task automatic build_run(input int d1, input int d2, input int m);
        repeat (d1) exp_q.push_back(V_D1);
        if (d1 > 0) repeat (DEAD) exp_q.push_back(V_SHUT);
        repeat (d2) exp_q.push_back(V_D2);
        if (d2 > 0) repeat (DEAD) exp_q.push_back(V_SHUT);
        repeat (m) exp_q.push_back(V_SHUT);
        exp_q.push_back(V_DONE);
    endtask

    // Reference model: advances on every rising edge using the sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                cur = V_IDLE;
            end else if (cur[2] && bus.abort) begin
                exp_q.delete();
                cur = V_ABORT;
            end else if (cur[2]) begin
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : V_IDLE;
            end else if (bus.start) begin
                build_run(int'(bus.dose1_cycles), int'(bus.dose2_cycles),
                          int'(bus.mix_cycles));
                cur = exp_q.pop_front();
            end else begin
                cur = V_IDLE;
            end
            if (cur[1]) n_done_model++;
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("outputs", 32'(dut_vec()), 32'(cur));
            check("valve_overlap", 32'(bus.pn_ctl1 | bus.pn_ctl2), 32'd1);
            if (bus.done === 1'b1) n_done_dut++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic int rand_dur();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 4) return 0;
        if (r == 19) return int'($urandom_range(9, 40));
        return int'($urandom_range(1, 7));
    endfunction

    task automatic set_durs(input int d1, input int d2, input int m);
        bus.dose1_cycles = CNT_W'(d1);
        bus.dose2_cycles = CNT_W'(d2);
        bus.mix_cycles   = CNT_W'(m);
    endtask

    task automatic start_run(input int d1, input int d2, input int m);
        @(posedge clk); #1;
        set_durs(d1, d2, m);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        logic [4:0] e;
        int guard;

        rst = 1'b1;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        set_durs(3, 2, 5);

        // Reset held with start high: reset values only.
        repeat (2) begin
            @(negedge clk);
            check("reset_state", 32'(dut_vec()), 32'(V_IDLE));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // Next edge samples start in IDLE: run 3/2/5 begins.
        @(posedge clk); #1;
        bus.start = 1'b0;
        set_durs(7, 7, 7);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
            if (k >= 1 && k <= 3) e[4] = 1'b0;
            if (k >= 8 && k <= 9) e[3] = 1'b0;
            e[2] = (k <= 19);
            e[1] = (k == 19);
            check($sformatf("run_3_2_5_k%0d", k), 32'(dut_vec()), 32'(e));
            @(posedge clk); #1;
            // Start pulses and duration changes mid-run must be ignored.
            bus.start = (k < 18) ? 1'($urandom_range(0, 1)) : 1'b0;
            set_durs(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                     int'($urandom_range(0, 9)));
        end
        bus.start = 1'b0;

        // Dose 1 and mix skipped.
        start_run(0, 4, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = {1'b1, (k > 4), (k <= 9), (k == 9), 1'b0};
            check($sformatf("run_0_4_0_k%0d", k), 32'(dut_vec()), 32'(e));
        end

        // Abort during the second cycle of DOSE2 (cycle 8 of a 2/5/3 run).
        start_run(2, 5, 3);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = {(k > 2), !(k == 7 || k == 8), (k <= 8), 1'b0, (k == 9)};
            check($sformatf("abort_dose2_k%0d", k), 32'(dut_vec()), 32'(e));
            @(posedge clk); #1;
            bus.abort = (k + 1 == 8);
        end
        bus.abort = 1'b0;

        // All durations zero: straight to DONE.
        start_run(0, 0, 0);
        @(negedge clk);
        check("all_zero_done", 32'(dut_vec()), 32'(V_DONE));
        @(negedge clk);
        check("all_zero_idle", 32'(dut_vec()), 32'(V_IDLE));

        // Randomized runs.
        for (int run = 0; run < 1000; run++) begin
            @(posedge clk); #1;
            set_durs(rand_dur(), rand_dur(), rand_dur());
            bus.start = 1'b1;
            bus.abort = ($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.abort = 1'b0;
            guard = 0;
            while (cur[2] && guard < 2000) begin
                bus.start = ($urandom_range(0, 3) == 0);
                bus.abort = ($urandom_range(0, 99) == 0);
                rst       = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 3) == 0)
                    set_durs(rand_dur(), rand_dur(), rand_dur());
                @(posedge clk); #1;
                guard++;
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
            rst       = 1'b0;
            if (guard >= 2000)
                check("run_timeout", 32'(guard), 32'd0);
            // Let any run started on the final edge drain.
            guard = 0;
            while (cur[2] && guard < 2000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 2000)
                check("drain_timeout", 32'(guard), 32'd0);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_count", 32'(n_done_dut), 32'(n_done_model));
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
